// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, show-ahead read data, occupancy count,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty,
  input  logic                       flush,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              wr_en;

  // Depth need not be a power of two, so pointers wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Acceptance uses the registered flags only; no same-cycle bypass.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign wr_en   = push_ok & ~flush & ~reset;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push_ok && !pop_ok)
      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_C == '0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= ptr_inc(wptr);
        if (pop_ok)  rptr <= ptr_inc(rptr);
      end
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
      // A new error event in the same cycle as err_clr keeps the flag set.
      if (push && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (pop && empty)  underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  // Storage carries data only and is never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(full && empty));
      assert ((count == DEPTH_C) == full);
      assert ((count == '0) == empty);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=5, AF_LEVEL=4, AE_LEVEL=1): a queue holds the
// expected read order and a negedge monitor compares rdata on every accepted pop.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset, push, pop, flush, err_clr;
  logic [7:0] wdata, rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .push(push), .wdata(wdata), .pop(pop), .rdata(rdata),
    .full(full), .empty(empty), .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .flush(flush), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Read-side monitor: an accepted pop must present the oldest expected word.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (!reset && !flush) begin
      if (pop && !empty) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rdata_pop: actual %02h popped, required no pop (nothing expected)", rdata);
        end else begin
          exp_d = exp_q.pop_front();
          if (rdata !== exp_d) begin
            n_err++;
            $display("FAIL rdata_pop: actual %02h required %02h", rdata, exp_d);
          end
        end
      end
      if (count > 3'd5) begin
        n_err++;
        $display("FAIL count_range: actual %0d required <= 5", count);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic [7:0] d, input logic q);
    push = p; wdata = d; pop = q;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; reset = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Fill with 0x11..0x55, then drain in order
    for (int i = 1; i <= 5; i++) begin
      push_exp(8'(i * 8'h11));
      chk("fill_count", count, i);
    end
    chk("fill_full", full, 1);
    chk("fill_af", almost_full, 1);
    chk("fill_ae", almost_empty, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Push while full with pop: pop accepted, push dropped, overflow set
    for (int i = 1; i <= 5; i++) push_exp(8'(i));
    cyc(1'b1, 8'h99, 1'b1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", full, 0);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("ovf_drain", count, 0);

    // Push and pop on empty: pop dropped, underflow set, A5 shows ahead
    exp_q.push_back(8'hA5);
    cyc(1'b1, 8'hA5, 1'b1);
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 1);
    chk("unf_rdata", rdata, 8'hA5);
    chk("unf_empty", empty, 0);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("unf_clr", underflow, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_drain", count, 0);

    // Steady push+pop at count 2 across several pointer wraps
    push_exp(8'h60);
    push_exp(8'h61);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'(8'h62 + i));
      cyc(1'b1, 8'(8'h62 + i), 1'b1);
      chk("stream_count", count, 2);
    end
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("stream_drain", count, 0);

    // Threshold stepping 0 -> 5 -> 0
    for (int i = 0; i < 5; i++) begin
      push_exp(8'(8'h70 + i));
      chk("up_ae", almost_empty, (i + 1) <= 1);
      chk("up_af", almost_full, (i + 1) >= 4);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("dn_count", count, 4 - i);
      chk("dn_ae", almost_empty, (4 - i) <= 1);
      chk("dn_af", almost_full, (4 - i) >= 4);
    end

    // Flush at count 3 with a push: contents gone, sticky flag kept
    cyc(1'b0, 8'h00, 1'b1);
    chk("flush_pre_unf", underflow, 1);
    push_exp(8'h80);
    push_exp(8'h81);
    push_exp(8'h82);
    flush = 1'b1;
    exp_q.delete();
    cyc(1'b1, 8'hEE, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_full", full, 0);
    chk("flush_unf", underflow, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("flush_hold", count, 0);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);

    // Reset mid-operation with both error flags set
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) push_exp(8'(8'h90 + i));
    cyc(1'b1, 8'h95, 1'b0);
    chk("pre_rst_ovf", overflow, 1);
    chk("pre_rst_unf", underflow, 1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pre_rst_count", count, 3);
    reset = 1'b1;
    exp_q.delete();
    cyc(1'b1, 8'hAA, 1'b1);
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_full", full, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_unf", underflow, 0);
    chk("mrst_ae", almost_empty, 1);
    chk("mrst_af", almost_full, 0);
    push_exp(8'h3C);
    chk("post_rst_rdata", rdata, 8'h3C);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_empty", empty, 1);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
